// File: rtl/serial_readout_mux.sv
// serial_readout_mux: captures NUM_CH parallel words and shifts the channels
// selected by ch_mask out MSB-first on sclk, back-to-back, with an optional
// even-parity bit per word. While idle it can pass the SPI register-readback
// bit straight through to serial_out.
module serial_readout_mux #(
  parameter int NUM_CH    = 8,
  parameter int WORD_W    = 8,
  parameter int PARITY_EN = 0,
  parameter int CNT_W     = 8,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     src_sel,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*WORD_W-1:0] raw_data,
  input  logic                     wr_serial_out,
  output logic                     serial_out,
  output logic [CNT_W-1:0]         load_cnt_ser,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1 + PARITY_EN);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                    state, state_nxt;
  logic [NUM_CH*WORD_W-1:0]  shadow_data, data_nxt;
  logic [NUM_CH-1:0]         shadow_mask, mask_nxt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [CH_W-1:0]           ch_nxt;
  logic [CH_W-1:0]           lowest_ch;
  logic [CH_W-1:0]           higher_ch;
  logic                      higher_found;
  logic                      done_nxt;
  logic                      bit_q, bit_nxt;
  logic [WORD_W-1:0]         word_nxt;
  logic [WORD_W-1:0]         word_shifted;

  // Channel search: lowest set bit of the incoming mask, and the next set
  // shadow-mask bit above the channel currently being shifted.
  always_comb begin
    lowest_ch    = '0;
    higher_ch    = '0;
    higher_found = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (ch_mask[i-1]) lowest_ch = CH_W'(i - 1);
      if (shadow_mask[i-1] && ((i - 1) > 32'(cur_ch))) begin
        higher_found = 1'b1;
        higher_ch    = CH_W'(i - 1);
      end
    end
  end

  // Next-state, counter and channel sequencing.
  always_comb begin
    state_nxt = state;
    data_nxt  = shadow_data;
    mask_nxt  = shadow_mask;
    cnt_nxt   = load_cnt_ser;
    ch_nxt    = cur_ch;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (|ch_mask) begin
            state_nxt = SHIFT;
            data_nxt  = raw_data;
            mask_nxt  = ch_mask;
            cnt_nxt   = '0;
            ch_nxt    = lowest_ch;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ch_nxt    = '0;
        end else if (load_cnt_ser == LAST_CNT) begin
          cnt_nxt = '0;
          if (higher_found) begin
            ch_nxt = higher_ch;
          end else begin
            state_nxt = IDLE;
            ch_nxt    = '0;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = load_cnt_ser + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data bit for the coming cycle, taken from the next shadow word so the
  // registered bit lines up with the registered counter and channel.
  always_comb begin
    word_nxt     = WORD_W'(data_nxt >> (32'(ch_nxt) * WORD_W));
    word_shifted = word_nxt << cnt_nxt;
    bit_nxt      = 1'b0;
    if (state_nxt == SHIFT) begin
      if (cnt_nxt < WORD_CNT) bit_nxt = word_shifted[WORD_W-1];
      else                    bit_nxt = ^word_nxt;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state        <= IDLE;
      shadow_data  <= '0;
      shadow_mask  <= '0;
      load_cnt_ser <= '0;
      cur_ch       <= '0;
      done         <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      shadow_data  <= data_nxt;
      shadow_mask  <= mask_nxt;
      load_cnt_ser <= cnt_nxt;
      cur_ch       <= ch_nxt;
      done         <= done_nxt;
      bit_q        <= bit_nxt;
    end
  end

  // Output select: shifted data while busy, readback passthrough when idle.
  always_comb begin
    busy       = (state == SHIFT);
    serial_out = busy ? bit_q : (src_sel & wr_serial_out);
  end

endmodule
